// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer with byte enables, lane replication, load extension and ready timeout.
// Optional LSU_MISALIGN_TRAP_EN adds misalign_o and traps misaligned H/W accesses.
module lsu_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        bus_err_o
`ifdef LSU_MISALIGN_TRAP_EN
  , output logic      misalign_o
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [31:0] addr_q, wd_q;
  logic [2:0] size_q;
  logic we_q;
  logic [WAIT_W-1:0] cnt;
  logic legal, misaligned;
  logic [1:0] a;
  logic [3:0] be;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [31:0] ext;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign misalign_o = mis_q;
  assign misaligned = (core_size_i[1:0] == 2'd1 && core_addr_i[0]) ||
                      (core_size_i == 3'd2 && core_addr_i[1:0] != 2'd0);
`else
  assign misaligned = 1'b0;
`endif
  assign legal = core_size_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  assign a = addr_q[1:0];
  assign be = size_q[1:0] == 2'd0 ? 4'b0001 << a :
              size_q[1:0] == 2'd1 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  assign lb = mem_rd_i[{a, 3'b000} +: 8];
  assign lh = mem_rd_i[{a[1], 4'b0000} +: 16];
  assign ext = size_q == 3'd0 ? {{24{lb[7]}}, lb} :
               size_q == 3'd1 ? {{16{lh[15]}}, lh} :
               size_q == 3'd4 ? {24'd0, lb} :
               size_q == 3'd5 ? {16'd0, lh} : mem_rd_i;
  // Stall is combinational in IDLE so the PC freezes in the request cycle itself.
  assign core_stall_o = !rst_i && (state == BUSY || (state == IDLE && core_req_i));
  assign mem_req_o = state == BUSY;
  assign mem_we_o = state == BUSY && we_q;
  assign mem_be_o = state == BUSY ? be : 4'b0000;
  assign mem_addr_o = {addr_q[31:2], 2'b00};
  assign mem_wd_o = size_q[1:0] == 2'd0 ? {4{wd_q[7:0]}} :
                    size_q[1:0] == 2'd1 ? {2{wd_q[15:0]}} : wd_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      addr_q <= '0;
      wd_q <= '0;
      size_q <= '0;
      we_q <= 1'b0;
      cnt <= '0;
      core_rd_o <= '0;
      bus_err_o <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
    end else begin
      bus_err_o <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
      case (state)
        IDLE: if (core_req_i) begin
          if (!legal || misaligned) begin
            state <= DONE;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q <= legal;
`endif
          end else begin
            addr_q <= core_addr_i;
            wd_q <= core_wd_i;
            size_q <= core_size_i;
            we_q <= core_we_i;
            cnt <= '0;
            state <= BUSY;
          end
        end
        BUSY: if (mem_ready_i) begin
          if (!we_q) core_rd_o <= ext;
          state <= DONE;
        end else if (MAX_WAIT != 0 && cnt == WAIT_W'(MAX_WAIT - 1)) begin
          bus_err_o <= 1'b1;
          state <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed checks of lsu_ctrl against a byte-lane reference model.
module tb_lsu_ctrl;
  logic clk = 0, rst = 1, req = 0, req4 = 0, we = 0, mready = 0;
  logic [2:0] size = 0;
  logic [31:0] addr = 0, wd = 0, mrd = 0;
  logic [31:0] rd, maddr, mwd, rd4, maddr4, mwd4;
  logic stall, mreq, mwe, err, stall4, mreq4, mwe4, err4;
  logic [3:0] mbe, mbe4;
  int checks = 0, errors = 0;
  logic [31:0] rd_model = 0;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis, mis4;
  localparam bit TRAP = 1;
`else
  localparam bit TRAP = 0;
`endif

  always #5 clk = ~clk;

  lsu_ctrl dut (.clk_i(clk), .rst_i(rst), .core_req_i(req), .core_we_i(we), .core_size_i(size),
    .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(rd), .core_stall_o(stall), .mem_req_o(mreq),
    .mem_we_o(mwe), .mem_be_o(mbe), .mem_addr_o(maddr), .mem_wd_o(mwd), .mem_rd_i(mrd),
    .mem_ready_i(mready), .bus_err_o(err)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_o(mis)
`endif
  );
  lsu_ctrl #(.MAX_WAIT(4), .WAIT_W(8)) dut4 (.clk_i(clk), .rst_i(rst), .core_req_i(req4),
    .core_we_i(we), .core_size_i(size), .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(rd4),
    .core_stall_o(stall4), .mem_req_o(mreq4), .mem_we_o(mwe4), .mem_be_o(mbe4),
    .mem_addr_o(maddr4), .mem_wd_o(mwd4), .mem_rd_i(mrd), .mem_ready_i(mready), .bus_err_o(err4)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_o(mis4)
`endif
  );

  function automatic int nbytes(input logic [2:0] s);
    return s[1:0] == 2'd0 ? 1 : s[1:0] == 2'd1 ? 2 : 4;
  endfunction
  function automatic bit is_legal(input logic [2:0] s);
    return s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction
  function automatic int lane(input logic [2:0] s, input logic [31:0] a);
    return (int'(a % 4) / nbytes(s)) * nbytes(s);
  endfunction
  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    logic [7:0] v;
    v = 8'((1 << nbytes(s)) - 1) << lane(s, a);
    return v[3:0];
  endfunction
  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] d);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = d[8*(i % nbytes(s)) +: 8];
    return v;
  endfunction
  function automatic logic [31:0] m_rd(input logic [2:0] s, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v, mask;
    int n;
    n = nbytes(s);
    mask = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
    v = (r >> (8 * lane(s, a))) & mask;
    if (!s[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic run_access(input logic w, input logic [2:0] s, input logic [31:0] a,
      input logic [31:0] d, input logic [31:0] r, input int wait_n,
      output int st_n, output int rq_n, output logic [3:0] be_o, output logic [31:0] wd_o,
      output logic [31:0] ad_o, output logic we_o, output logic [31:0] rd_o, output logic err_o,
      output logic mis_o, output logic done, output logic stable);
    st_n = 0; rq_n = 0; be_o = 0; wd_o = 0; ad_o = 0; we_o = 0; rd_o = 0; err_o = 0;
    mis_o = 0; done = 0; stable = 1;
    @(posedge clk); #1;
    req = 1; we = w; size = s; addr = a; wd = d; mrd = r; mready = 1'($urandom);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (c > 0 && !stall) begin
        done = 1; rd_o = rd; err_o = err; req = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_o = mis;
`endif
      end else begin
        st_n += int'(stall);
        if (mreq) begin
          if (rq_n == 0) begin be_o = mbe; wd_o = mwd; ad_o = maddr; we_o = mwe; end
          else if (mbe !== be_o || mwd !== wd_o || maddr !== ad_o || mwe !== we_o) stable = 0;
          rq_n++;
          mready = rq_n > wait_n;
        end else mready = 1'($urandom);
        if (c == 1) begin
          req = 1'($urandom); we = 1'($urandom); size = 3'($urandom); addr = $urandom; wd = $urandom;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1; req = 1;
    #2;
    checks++; if (stall !== 0 || mreq !== 0) begin errors++; $display("FAIL reset_async stall=%b req=%b required 0 0", stall, mreq); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd !== 0 || mbe !== 0 || mwe !== 0 || err !== 0) begin errors++; $display("FAIL reset_state rd=%h be=%b we=%b err=%b required 0", rd, mbe, mwe, err); end
    req = 0; rst = 0; rd_model = 0;
  endtask

  task automatic test_directed;
    int st, rq; logic [3:0] b; logic [31:0] w, ad, r; logic e, m, dn, sb, wv;
    run_access(0, 3'd2, 32'h100, 0, 32'h89AB_CDEF, 0, st, rq, b, w, ad, wv, r, e, m, dn, sb);
    checks++; if (!dn || r !== 32'h89AB_CDEF || st !== 2 || b !== 4'b1111 || ad !== 32'h100) begin errors++; $display("FAIL lw rd=%h st=%0d be=%b addr=%h required 89abcdef 2 1111 00000100", r, st, b, ad); end
    run_access(1, 3'd0, 32'h203, 32'hA5, 0, 0, st, rq, b, w, ad, wv, r, e, m, dn, sb);
    checks++; if (b !== 4'b1000 || w !== 32'hA5A5_A5A5 || wv !== 1 || ad !== 32'h200 || r !== 32'h89AB_CDEF) begin errors++; $display("FAIL sb be=%b wd=%h we=%b addr=%h rd=%h required 1000 a5a5a5a5 1 00000200 89abcdef", b, w, wv, ad, r); end
    run_access(0, 3'd0, 32'h2, 0, 32'h0080_0000, 1, st, rq, b, w, ad, wv, r, e, m, dn, sb);
    checks++; if (r !== 32'hFFFF_FF80 || b !== 4'b0100) begin errors++; $display("FAIL lb rd=%h be=%b required ffffff80 0100", r, b); end
    run_access(0, 3'd4, 32'h2, 0, 32'h0080_0000, 0, st, rq, b, w, ad, wv, r, e, m, dn, sb);
    checks++; if (r !== 32'h0000_0080) begin errors++; $display("FAIL lbu rd=%h required 00000080", r); end
    run_access(0, 3'd1, 32'h2, 0, 32'hFFFE_0000, 0, st, rq, b, w, ad, wv, r, e, m, dn, sb);
    checks++; if (r !== 32'hFFFF_FFFE || b !== 4'b1100) begin errors++; $display("FAIL lh rd=%h be=%b required fffffffe 1100", r, b); end
    run_access(0, 3'd3, 32'h10, 0, 32'h1111_1111, 0, st, rq, b, w, ad, wv, r, e, m, dn, sb);
    checks++; if (rq !== 0 || st !== 1 || r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL illegal rq=%0d st=%0d rd=%h required 0 1 fffffffe", rq, st, r); end
    rd_model = 32'hFFFF_FFFE;
  endtask

  task automatic test_wait;
    int st, rq; logic [3:0] b; logic [31:0] w, ad, r; logic e, m, dn, sb, wv;
    run_access(0, 3'd2, 32'h40, 0, 32'h0BAD_F00D, 5, st, rq, b, w, ad, wv, r, e, m, dn, sb);
    checks++; if (rq !== 6 || st !== 7 || r !== 32'h0BAD_F00D || e !== 0 || !sb) begin errors++; $display("FAIL wait5 rq=%0d st=%0d rd=%h err=%b stable=%b required 6 7 0badf00d 0 1", rq, st, r, e, sb); end
    rd_model = 32'h0BAD_F00D;
  endtask

  task automatic test_random;
    int st, rq, wn; logic [3:0] b; logic [31:0] w, ad, r, a, d, rr; logic e, m, dn, sb, wv, wr;
    logic [2:0] s; bit go, trap;
    for (int i = 0; i < 60; i++) begin
      s = 3'($urandom); a = $urandom; d = $urandom; rr = $urandom; wr = 1'($urandom);
      wn = $urandom_range(0, 3);
      run_access(wr, s, a, d, rr, wn, st, rq, b, w, ad, wv, r, e, m, dn, sb);
      trap = TRAP && is_legal(s) && (a % nbytes(s)) != 0;
      go = is_legal(s) && !trap;
      if (go && !wr) rd_model = m_rd(s, a, rr);
      checks++; if (!dn || st !== (go ? wn + 2 : 1) || rq !== (go ? wn + 1 : 0) || e !== 0) begin errors++; $display("FAIL rand_timing i=%0d st=%0d rq=%0d err=%b size=%0d", i, st, rq, e, s); end
      checks++; if (r !== rd_model) begin errors++; $display("FAIL rand_rd i=%0d got=%h required=%h size=%0d addr=%h", i, r, rd_model, s, a); end
      checks++; if (m !== trap) begin errors++; $display("FAIL rand_mis i=%0d got=%b required=%b", i, m, trap); end
      if (go) begin
        checks++; if (b !== m_be(s, a) || ad !== {a[31:2], 2'b00} || wv !== wr || !sb) begin errors++; $display("FAIL rand_bus i=%0d be=%b addr=%h we=%b stable=%b required %b %h %b 1", i, b, ad, wv, sb, m_be(s, a), {a[31:2], 2'b00}, wr); end
        if (wr) begin
          checks++; if (w !== m_wd(s, d)) begin errors++; $display("FAIL rand_wd i=%0d got=%h required=%h", i, w, m_wd(s, d)); end
        end
      end
    end
  endtask

  task automatic test_timeout;
    int busy, errs; bit dn;
    @(posedge clk); #1;
    req4 = 1; we = 0; size = 3'd2; addr = 32'h40; mrd = 32'h1234_5678; mready = 1;
    dn = 0;
    for (int c = 0; c < 20 && !dn; c++) begin
      @(negedge clk);
      if (c == 1) req4 = 0;
      if (c > 0 && !stall4) dn = 1;
    end
    checks++; if (!dn || rd4 !== 32'h1234_5678) begin errors++; $display("FAIL to_load rd=%h required 12345678", rd4); end
    @(posedge clk); #1;
    req4 = 1; addr = 32'h44; mrd = $urandom; mready = 0; busy = 0; errs = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 1) req4 = 0;
      busy += int'(mreq4);
      if (err4) begin
        errs++;
        checks++; if (stall4 !== 0) begin errors++; $display("FAIL to_err_stall stall=%b required 0", stall4); end
      end
    end
    checks++; if (busy !== 4 || errs !== 1 || rd4 !== 32'h1234_5678) begin errors++; $display("FAIL timeout busy=%0d errpulses=%0d rd=%h required 4 1 12345678", busy, errs, rd4); end
  endtask

  task automatic test_reset_mid_busy;
    int st, rq; logic [3:0] b; logic [31:0] w, ad, r; logic e, m, dn, sb, wv;
    @(posedge clk); #1;
    req = 1; we = 0; size = 3'd2; addr = 32'h300; mrd = 32'h5555_AAAA; mready = 0;
    @(posedge clk); #2;
    checks++; if (mreq !== 1) begin errors++; $display("FAIL rst_mid_pre req=%b required 1", mreq); end
    rst = 1;
    #1;
    checks++; if (mreq !== 0 || stall !== 0 || rd !== 0 || mbe !== 0) begin errors++; $display("FAIL rst_mid req=%b stall=%b rd=%h be=%b required 0 0 0 0", mreq, stall, rd, mbe); end
    req = 0;
    @(negedge clk); rst = 0; rd_model = 0;
    run_access(0, 3'd2, 32'h304, 0, 32'hCAFE_BABE, 0, st, rq, b, w, ad, wv, r, e, m, dn, sb);
    checks++; if (!dn || r !== 32'hCAFE_BABE || st !== 2 || rq !== 1) begin errors++; $display("FAIL rst_mid_after rd=%h st=%0d rq=%0d required cafebabe 2 1", r, st, rq); end
    rd_model = 32'hCAFE_BABE;
  endtask

  task automatic test_misalign;
    int st, rq; logic [3:0] b; logic [31:0] w, ad, r; logic e, m, dn, sb, wv;
    run_access(0, 3'd2, 32'h102, 0, 32'h7777_0001, 0, st, rq, b, w, ad, wv, r, e, m, dn, sb);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (rq !== 0 || m !== 1 || st !== 1 || r !== rd_model) begin errors++; $display("FAIL misalign_trap rq=%0d mis=%b st=%0d rd=%h required 0 1 1 %h", rq, m, st, r, rd_model); end
`else
    checks++; if (rq !== 1 || ad !== 32'h100 || b !== 4'b1111 || r !== 32'h7777_0001) begin errors++; $display("FAIL misalign_align rq=%0d addr=%h be=%b rd=%h required 1 00000100 1111 77770001", rq, ad, b, r); end
    rd_model = 32'h7777_0001;
`endif
  endtask

  initial begin
    test_reset;
    test_directed;
    test_wait;
    test_random;
    test_timeout;
    test_reset_mid_busy;
    test_misalign;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between processor_core memory-side outputs (mem_req/we/size/addr/wd) and a variable-latency data memory with a ready handshake.
- Drives processor_core stall_i so the PC and register-file write are held until the access completes.
- Generates byte enables and lane-replicated write data, and sign/zero-extends load data.
- Aborts accesses the memory never acknowledges.

Parameters:
- MAX_WAIT, 255: BUSY cycles without mem_ready_i before abort; 0 disables the timeout.
- WAIT_W, 8: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- core_req_i  in  1  core requests a memory access
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, LSB-aligned
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  to processor_core stall_i
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word address, bits [1:0] forced 0
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory completes the access this cycle
- bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:

Reset (async, rst_i=1):
- state=IDLE.
- All registers 0: core_rd_o=0, latched addr/size/we/wd, wait counter.
- mem_req_o=0, core_stall_o=0, bus_err_o=0 immediately, without waiting for a clock edge.

FSM states: IDLE, BUSY, DONE.

IDLE:
- core_stall_o = core_req_i (combinational, so the PC holds in the same cycle).
- On core_req_i=1 with a legal size: latch addr, size, we, wd; clear the wait counter; go to BUSY.
- Illegal size (3, 6, 7): go to DONE, no memory access, core_rd_o unchanged.

BUSY:
- mem_req_o=1, core_stall_o=1.
- mem_we_o, mem_be_o, mem_addr_o, mem_wd_o come from the latched values.
- Outside BUSY: mem_we_o=0 and mem_be_o=0.
- mem_ready_i=1: for a load, register the extended data into core_rd_o; go to DONE.
- Otherwise increment the wait counter.
- Counter reaches MAX_WAIT (MAX_WAIT≠0) without ready: bus_err_o=1 for one cycle, go to DONE, core_rd_o unchanged.

DONE:
- core_stall_o=0 for exactly one cycle; the core commits the instruction on this edge.
- Next state is IDLE unconditionally.
- A request present in DONE is seen in the following IDLE cycle.

Latency and handshake:
- Minimum access = 3 cycles (IDLE, BUSY with ready, DONE); stall is high for 2 of them.
- core_req_i deasserting during BUSY is ignored: the latched access completes.
- Core inputs changing during BUSY are ignored.
- mem_ready_i outside BUSY is ignored.

Byte enables (a = latched addr[1:0]):
- B/BU: 4'b0001<<a.
- H/HU: 4'b0011<<{a[1],0}.
- W: 4'b1111.

Store data:
- B: {4{wd[7:0]}}.
- H: {2{wd[15:0]}}.
- W: wd.

Load data:
- Select byte lane a, or halfword lane a[1].
- B/H: sign-extend. BU/HU: zero-extend. W: whole word.
- core_rd_o holds its value until the next load completion.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_o (1 bit).
  - H/HU with addr[0]=1, or W with addr[1:0]≠0: IDLE goes directly to DONE, with no mem_req_o and core_rd_o unchanged.
  - misalign_o=1 during that DONE cycle only; reset value 0.
- Undefined:
  - No misalign_o port.
  - Misaligned addresses are silently aligned: H uses addr[1] only, W ignores addr[1:0].

Test Plan:
1. LW, addr 0x100, mem_rd_i=0x89ABCDEF, ready on the first BUSY cycle -> mem_addr_o=0x100, mem_be_o=1111; core_rd_o=0x89ABCDEF in DONE; stall high exactly 2 cycles.
2. SB, addr 0x203, wd=0x000000A5 -> mem_be_o=1000, mem_wd_o=0xA5A5A5A5, mem_we_o=1, mem_addr_o=0x200.
3. LB/LBU, addr 0x2, mem_rd_i=0x00800000 -> LB gives core_rd_o=0xFFFFFF80; LBU gives 0x00000080. LH addr 0x2, mem_rd_i=0xFFFE0000 -> 0xFFFFFFFE.
4. LW with mem_ready_i low for 5 BUSY cycles (MAX_WAIT=255) -> mem_req_o high 6 cycles, stall high 7 cycles, then one DONE cycle. With MAX_WAIT=4 and ready never asserted -> bus_err_o pulses once after 4 BUSY cycles, core_rd_o unchanged.
5. rst_i asserted mid-BUSY -> mem_req_o and core_stall_o drop before the next clock edge; core_rd_o=0; after release, a new LW completes normally.
6. With LSU_MISALIGN_TRAP_EN defined, LW at addr 0x102 -> no mem_req_o, misalign_o=1 for one cycle, stall high 1 cycle. Without the macro -> access issued at 0x100 with mem_be_o=1111.
